hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage riscky core (F/D/E/M/W). Sits beside the decode and execute stages.
- Generates E-stage operand forwarding selects, load-use stalls, branch/jump flushes and whole-pipeline freezes during data-memory wait states.
- Holds fetch through a post-reset boot window.
- Keeps saturating stall/flush event counters and a sticky memory-timeout flag for debug.

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the riscky 5-stage core: forwarding, load-use
// stalls, redirect flushes, memory-wait freezes, boot hold and debug counters.
module hazard_ctrl #(
   parameter int BOOT_CYCLES = 2,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rs1_e,
   input  logic [4:0]       rs2_e,
   input  logic [4:0]       rd_e,
   input  logic             reg_write_e,
   input  logic             result_src_e,
   input  logic             pc_src_e,
   input  logic [4:0]       rd_m,
   input  logic             reg_write_m,
   input  logic [4:0]       rd_w,
   input  logic             reg_write_w,
   input  logic             mem_req_m,
   input  logic             mem_ready_m,
   output logic [1:0]       forward_a_e,
   output logic [1:0]       forward_b_e,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout
);

   typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, MEM_WAIT = 2'b10} state_t;

   localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam state_t          RST_STATE = (BOOT_CYCLES == 0) ? RUN : BOOT;
   localparam logic [BW-1:0]   BOOT_LAST = BW'(BOOT_CYCLES - 1);
   localparam logic [WW-1:0]   WAIT_MAX  = WW'(MEM_TIMEOUT);
   localparam logic [WW-1:0]   WAIT_LAST = WW'(MEM_TIMEOUT - 1);

   state_t          state_q, state_nx;
   logic [BW-1:0]   boot_cnt;
   logic [WW-1:0]   wait_cnt;
   logic            freeze, lu, boot_out;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] m_rd, input logic m_we,
                                          input logic [4:0] w_rd, input logic w_we);
      if (m_we && m_rd != 5'd0 && m_rd == rs)      return 2'b10;
      else if (w_we && w_rd != 5'd0 && w_rd == rs) return 2'b01;
      else                                         return 2'b00;
   endfunction

   assign freeze   = mem_req_m & ~mem_ready_m;
   assign lu       = result_src_e & reg_write_e & (rd_e != 5'd0) &
                     ((rd_e == rs1_d) | (rd_e == rs2_d));
   // Holding reset forces the boot pattern even before the state register settles.
   assign boot_out = ~rst_n | (state_q == BOOT);
   assign state    = state_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= RST_STATE;
      else        state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         BOOT:     if (boot_cnt == BOOT_LAST) state_nx = RUN;
         RUN:      if (freeze)                state_nx = MEM_WAIT;
         MEM_WAIT: if (!freeze)               state_nx = RUN;
         default:                             state_nx = RST_STATE;
      endcase
   end

   always_comb begin
      forward_a_e = 2'b00;
      forward_b_e = 2'b00;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_e     = 1'b0;
      stall_m     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      if (boot_out) begin
         stall_f = 1'b1;
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else begin
         forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
         forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
         if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
         end else begin
            flush_d = pc_src_e;
            flush_e = pc_src_e | lu;
            stall_f = lu & ~pc_src_e;
            stall_d = lu & ~pc_src_e;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         boot_cnt    <= '0;
         wait_cnt    <= '0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         mem_timeout <= 1'b0;
      end else if (state_q == BOOT) begin
         boot_cnt <= boot_cnt + 1'b1;
         wait_cnt <= '0;
      end else begin
         if (freeze) begin
            if (wait_cnt != WAIT_MAX)  wait_cnt    <= wait_cnt + 1'b1;
            if (wait_cnt >= WAIT_LAST) mem_timeout <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
         if (stall_f && stall_cnt != '1)               stall_cnt <= stall_cnt + 1'b1;
         if (pc_src_e && !freeze && flush_cnt != '1)   flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a rule-level reference model checked every cycle.
module tb_hazard_ctrl;

   localparam int BC  = 2;
   localparam int MT  = 3;
   localparam int CW  = 6;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic          reg_write_e, result_src_e, pc_src_e, reg_write_m, reg_write_w;
   logic          mem_req_m, mem_ready_m;
   logic [1:0]    forward_a_e, forward_b_e, state;
   logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, mem_timeout;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.BOOT_CYCLES(BC), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
      .pc_src_e(pc_src_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
      .rd_w(rd_w), .reg_write_w(reg_write_w),
      .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .state(state),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: boot cycles left, counters, wait run length.
   int boot_left = 0, m_stall = 0, m_flush = 0, m_wait = 0;
   bit m_timeout = 0, m_in_wait = 0, m_valid = 0;

   function automatic int sel(input logic [4:0] rs);
      if (reg_write_m && rd_m != 0 && rd_m == rs) return 2;
      if (reg_write_w && rd_w != 0 && rd_w == rs) return 1;
      return 0;
   endfunction

   function automatic void model_out(output int fa, output int fb, output bit sf,
                                     output bit sd, output bit se, output bit sm,
                                     output bit fd, output bit fe);
      bit frz, hz;
      fa = 0; fb = 0; sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0;
      if (!rst_n || boot_left > 0) begin
         sf = 1; fd = 1; fe = 1;
      end else begin
         fa  = sel(rs1_e);
         fb  = sel(rs2_e);
         frz = mem_req_m && !mem_ready_m;
         hz  = result_src_e && reg_write_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
         if (frz) begin
            sf = 1; sd = 1; se = 1; sm = 1;
         end else begin
            fd = pc_src_e;
            fe = pc_src_e || hz;
            sf = hz && !pc_src_e;
            sd = sf;
         end
      end
   endfunction

   always @(posedge clk) begin
      int fa, fb;
      bit sf, sd, se, sm, fd, fe, frz;
      if (!rst_n) begin
         boot_left = BC; m_stall = 0; m_flush = 0; m_wait = 0;
         m_timeout = 0; m_in_wait = 0; m_valid = 1;
      end else if (m_valid) begin
         if (boot_left > 0) begin
            boot_left--;
            m_wait = 0;
         end else begin
            model_out(fa, fb, sf, sd, se, sm, fd, fe);
            frz = mem_req_m && !mem_ready_m;
            if (sf && m_stall < SAT) m_stall++;
            if (pc_src_e && !frz && m_flush < SAT) m_flush++;
            if (frz) begin
               if (m_wait < MT) m_wait++;
               if (m_wait >= MT) m_timeout = 1;
            end else begin
               m_wait = 0;
            end
            m_in_wait = frz;
         end
      end
   end

   always @(negedge clk) begin
      int fa, fb;
      bit sf, sd, se, sm, fd, fe;
      if (m_valid) begin
         model_out(fa, fb, sf, sd, se, sm, fd, fe);
         chk("fwd_a", forward_a_e, fa);
         chk("fwd_b", forward_b_e, fb);
         chk("stall_f", stall_f, sf);
         chk("stall_d", stall_d, sd);
         chk("stall_e", stall_e, se);
         chk("stall_m", stall_m, sm);
         chk("flush_d", flush_d, fd);
         chk("flush_e", flush_e, fe);
         chk("state", state, (boot_left > 0) ? 0 : (m_in_wait ? 2 : 1));
         chk("stall_cnt", stall_cnt, m_stall);
         chk("flush_cnt", flush_cnt, m_flush);
         chk("mem_timeout", mem_timeout, m_timeout);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
      {reg_write_e, result_src_e, pc_src_e, reg_write_m, reg_write_w} = '0;
      {mem_req_m, mem_ready_m} = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      clr();
      tick(); tick();
      @(negedge clk);
      chk("L rst stall_f", stall_f, 1); chk("L rst flush_e", flush_e, 1);
      chk("L rst state", state, 0);     chk("L rst stall_cnt", stall_cnt, 0);

      // Boot window with noisy inputs that must be ignored
      tick(); rst_n = 1'b1; mem_req_m = 1; pc_src_e = 1;
      @(negedge clk); chk("L boot0 state", state, 0); chk("L boot0 stall_m", stall_m, 0);
      tick();
      @(negedge clk); chk("L boot1 stall_f", stall_f, 1); chk("L boot1 flush_e", flush_e, 1);
      tick(); clr();
      @(negedge clk);
      chk("L run state", state, 1); chk("L run stall_f", stall_f, 0);
      chk("L run stall_cnt", stall_cnt, 0); chk("L run flush_cnt", flush_cnt, 0);
      chk("L run timeout", mem_timeout, 0);

      // Forwarding on operand A
      tick(); rs1_e = 5; rd_m = 5; reg_write_m = 1;
      @(negedge clk); chk("L fa M", forward_a_e, 2);
      tick(); rd_m = 7; rd_w = 5; reg_write_w = 1;
      @(negedge clk); chk("L fa W", forward_a_e, 1);
      tick(); rd_m = 5;
      @(negedge clk); chk("L fa prio", forward_a_e, 2);
      tick(); rd_m = 0; rd_w = 0;
      @(negedge clk); chk("L fa none", forward_a_e, 0);
      tick(); rs1_e = 0;
      @(negedge clk); chk("L fa x0", forward_a_e, 0);
      // Forwarding on operand B
      tick(); clr(); rs2_e = 5; rd_m = 5; reg_write_m = 1;
      @(negedge clk); chk("L fb M", forward_b_e, 2); chk("L fa idle", forward_a_e, 0);
      tick(); rd_m = 7; rd_w = 5; reg_write_w = 1;
      @(negedge clk); chk("L fb W", forward_b_e, 1);
      tick(); rd_m = 0; rd_w = 0;
      @(negedge clk); chk("L fb none", forward_b_e, 0);

      // Load-use
      tick(); clr(); result_src_e = 1; reg_write_e = 1; rd_e = 3; rs2_d = 3;
      @(negedge clk);
      chk("L lu stall_f", stall_f, 1); chk("L lu stall_d", stall_d, 1);
      chk("L lu flush_e", flush_e, 1); chk("L lu flush_d", flush_d, 0);
      tick(); clr();
      @(negedge clk); chk("L lu once", stall_f, 0); chk("L lu cnt", stall_cnt, 1);
      tick(); result_src_e = 1; reg_write_e = 1;
      @(negedge clk); chk("L lu x0", stall_f, 0); chk("L lu x0 fe", flush_e, 0);

      // Redirect together with load-use
      tick(); rd_e = 3; rs1_d = 3; pc_src_e = 1;
      @(negedge clk);
      chk("L rd flush_d", flush_d, 1); chk("L rd flush_e", flush_e, 1); chk("L rd stall_f", stall_f, 0);
      tick(); clr();
      @(negedge clk); chk("L rd flush_cnt", flush_cnt, 1); chk("L rd stall_cnt", stall_cnt, 1);

      // Short wait, released by mem_req dropping
      tick(); mem_req_m = 1;
      @(negedge clk); chk("L sw stall_e", stall_e, 1); chk("L sw state0", state, 1);
      tick();
      @(negedge clk); chk("L sw state1", state, 2); chk("L sw timeout", mem_timeout, 0);
      tick(); mem_req_m = 0;
      @(negedge clk); chk("L sw rel", stall_f, 0); chk("L sw timeout2", mem_timeout, 0);
      tick();
      @(negedge clk); chk("L sw state2", state, 1); chk("L sw cnt", stall_cnt, 3);

      // Four-cycle wait with a pending redirect; timeout after third freeze cycle
      tick(); mem_req_m = 1; pc_src_e = 1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         @(negedge clk);
         chk("L lw stall_m", stall_m, 1); chk("L lw flush_d", flush_d, 0);
         chk("L lw timeout", mem_timeout, (i == 3) ? 1 : 0);
      end
      tick(); mem_ready_m = 1;
      @(negedge clk); chk("L lw rel fd", flush_d, 1); chk("L lw rel fe", flush_e, 1);
      tick(); clr();
      @(negedge clk);
      chk("L lw state", state, 1); chk("L lw stall_cnt", stall_cnt, 7);
      chk("L lw flush_cnt", flush_cnt, 2); chk("L lw sticky", mem_timeout, 1);

      // Back-to-back waits
      tick(); mem_req_m = 1;
      tick(); mem_ready_m = 1;
      tick(); mem_ready_m = 0;
      tick(); clr();

      // stall_cnt saturation
      tick(); mem_req_m = 1;
      repeat (60) tick();
      @(negedge clk); chk("L stall sat", stall_cnt, SAT);

      // Reset in the middle of a wait
      tick(); rst_n = 1'b0;
      @(negedge clk);
      chk("L mr stall_e", stall_e, 0); chk("L mr flush_d", flush_d, 1); chk("L mr state", state, 2);
      tick();
      @(negedge clk);
      chk("L mr state2", state, 0); chk("L mr timeout", mem_timeout, 0);
      chk("L mr stall_cnt", stall_cnt, 0); chk("L mr flush_cnt", flush_cnt, 0);

      // flush_cnt saturation
      tick(); rst_n = 1'b1; clr();
      tick(); tick(); pc_src_e = 1;
      repeat (66) tick();
      @(negedge clk); chk("L flush sat", flush_cnt, SAT);
      tick(); clr();
      tick();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
